control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the accumulator datapath: opcode/status
// in, instruction-cycle and accumulator controls out.
interface control_unit_if;
   logic [7:5] IR;
   logic       Aeq0;
   logic       Apos;
   logic       Enter;
   logic       IRload;
   logic       JMPmux;
   logic       PCload;
   logic       Meminst;
   logic       MemWr;
   logic       Aload;
   logic       Sub;
   logic [1:0] Asel;
   logic       Halt;

   modport master (
      input  IR, Aeq0, Apos, Enter,
      output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt
   );

   modport slave (
      output IR, Aeq0, Apos, Enter,
      input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt
   );
endinterface

// File: rtl/control_unit.sv
// Instruction-cycle FSM for the simple accumulator CPU: fetch, decode, execute.
// Optional macro CTRL_HALT_RESUME_EN lets Enter resume execution from HALT.
module control_unit #(
   parameter int unsigned MEM_WAIT = 0
) (
   input logic            Clock,
   input logic            Reset,
   control_unit_if.master bus
);
   localparam int unsigned WAIT_W = 4;

   typedef enum logic [3:0] {
      START  = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      LOAD   = 4'd3,
      STORE  = 4'd4,
      ADD    = 4'd5,
      SUB    = 4'd6,
      INPUT  = 4'd7,
      JZ     = 4'd8,
      JPOS   = 4'd9,
      HALT   = 4'd10
   } stateT;

   stateT             state;
   stateT             nextState;
   logic [WAIT_W-1:0] waitCnt;
   logic [WAIT_W-1:0] nextWaitCnt;
   logic              lastFetch;

   logic       irLoad;
   logic       jmpMux;
   logic       pcLoad;
   logic       memInst;
   logic       memWr;
   logic       aLoad;
   logic       subSel;
   logic [1:0] aSel;
   logic       halt;

   // FETCH spans MEM_WAIT+1 cycles; the instruction is latched on the last one
   assign lastFetch = (waitCnt == WAIT_W'(MEM_WAIT));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= START;
         waitCnt <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= nextWaitCnt;
      end
   end

   always_comb begin
      nextState   = START;
      nextWaitCnt = '0;
      irLoad      = 1'b0;
      jmpMux      = 1'b0;
      pcLoad      = 1'b0;
      memInst     = 1'b0;
      memWr       = 1'b0;
      aLoad       = 1'b0;
      subSel      = 1'b0;
      aSel        = 2'b00;
      halt        = 1'b0;
      case (state)
         START: nextState = FETCH;
         FETCH: begin
            if (lastFetch) begin
               irLoad    = 1'b1;
               pcLoad    = 1'b1;
               nextState = DECODE;
            end else begin
               nextWaitCnt = waitCnt + WAIT_W'(1);
               nextState   = FETCH;
            end
         end
         DECODE: begin
            memInst = 1'b1;
            case (bus.IR)
               3'b000:  nextState = LOAD;
               3'b001:  nextState = STORE;
               3'b010:  nextState = ADD;
               3'b011:  nextState = SUB;
               3'b100:  nextState = INPUT;
               3'b101:  nextState = JZ;
               3'b110:  nextState = JPOS;
               default: nextState = HALT;
            endcase
         end
         LOAD: begin
            memInst   = 1'b1;
            aSel      = 2'b10;
            aLoad     = 1'b1;
            nextState = FETCH;
         end
         STORE: begin
            memInst   = 1'b1;
            memWr     = 1'b1;
            nextState = FETCH;
         end
         ADD: begin
            memInst   = 1'b1;
            aLoad     = 1'b1;
            nextState = FETCH;
         end
         SUB: begin
            memInst   = 1'b1;
            aLoad     = 1'b1;
            subSel    = 1'b1;
            nextState = FETCH;
         end
         INPUT: begin
            aSel      = 2'b01;
            aLoad     = bus.Enter;
            nextState = bus.Enter ? FETCH : INPUT;
         end
         JZ: begin
            jmpMux    = bus.Aeq0;
            pcLoad    = bus.Aeq0;
            nextState = FETCH;
         end
         JPOS: begin
            jmpMux    = bus.Apos;
            pcLoad    = bus.Apos;
            nextState = FETCH;
         end
         HALT: begin
            halt = 1'b1;
`ifdef CTRL_HALT_RESUME_EN
            nextState = bus.Enter ? FETCH : HALT;
`else
            nextState = HALT;
`endif
         end
         default: nextState = START;
      endcase
   end

   assign bus.IRload  = irLoad;
   assign bus.JMPmux  = jmpMux;
   assign bus.PCload  = pcLoad;
   assign bus.Meminst = memInst;
   assign bus.MemWr   = memWr;
   assign bus.Aload   = aLoad;
   assign bus.Sub     = subSel;
   assign bus.Asel    = aSel;
   assign bus.Halt    = halt;
endmodule
